calc_cmd_sequencer: RTL
=======================

# calc_cmd_sequencer

Command sequencer between the UART receive path and the calculator ALU. It consumes received ASCII bytes and assembles them into `<operand A><operator><operand B>=`. It then launches one ALU operation with a single-cycle start pulse and holds off further input until the ALU reports completion. Malformed input latches an error that only a clear key removes.

## Interface
Parameters:
- `DIGITS`, 4: maximum decimal digits per operand.
- `WIDTH`, 16: operand width. Must hold 10^DIGITS−1.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `rx_valid`, in, 1: one-cycle strobe; `rx_data` is valid this cycle.
- `rx_data`, in, 8: received ASCII byte.
- `calc_done`, in, 1: one-cycle pulse from the ALU when the result is ready.
- `op_a`, out, WIDTH: operand A, binary.
- `op_b`, out, WIDTH: operand B, binary.
- `op_code`, out, 2: operator. 00 `+`, 01 `-`, 10 `*`, 11 `/`.
- `calc_start`, out, 1: one-cycle launch pulse to the ALU.
- `busy`, out, 1: high in START and WAIT.
- `err`, out, 1: high in ERR.

## Operation
States:
- **A**: digits `'0'`–`'9'` (0x30–0x39) update `op_a <= op_a*10 + (rx_data−0x30)` and increment `cnt_a`.
  - Operator `+ - * /` (0x2B, 0x2D, 0x2A, 0x2F) with `cnt_a ≥ 1` latches `op_code` and goes to B.
- **B**: digits update `op_b` and `cnt_b` the same way.
  - `'='` (0x3D) or CR (0x0D) with `cnt_b ≥ 1` goes to START.
  - If `op_code == 11` and `op_b == 0`, goes to ERR instead (divide by zero).
- **START**: lasts exactly one cycle with `calc_start = 1`, then goes to WAIT.
- **WAIT**: every `rx_valid` byte is dropped, including clear keys. `calc_done` goes to A.
- **ERR**: `err = 1`. All bytes except clear keys are dropped.

Transitions into ERR, from A or B:
- Any byte that is not a digit, operator, `=`, CR or clear key.
- A digit when the current operand's count already equals `DIGITS`.
- An operator in A with `cnt_a = 0`.
- A second operator in B.
- `=` or CR in A, or in B with `cnt_b = 0`.

Clear keys: `'C'` (0x43), `'c'` (0x63), ESC (0x1B). In A, B or ERR, a clear key goes to A.

Entering A, from any source, clears `op_a`, `op_b`, `op_code`, `cnt_a`, `cnt_b` and `err`.

Arithmetic:
- Multiply-accumulate is computed in WIDTH bits. The parameter constraint guarantees no overflow.
- `cnt_a` and `cnt_b` are `$clog2(DIGITS+1)` bits wide.

`op_a`, `op_b` and `op_code` stay stable from START until `calc_done`, so the ALU may sample them at any point in that interval.

## Timing
- Reset values: state A; `op_a = op_b = 0`; `op_code = 00`; `calc_start = busy = err = 0`.
- Bytes are processed in the `rx_valid` cycle. Register and state updates appear after the next rising edge.
- Back-to-back `rx_valid` on consecutive cycles is fully supported. No byte is lost in A, B or ERR.
- `calc_start` rises on the edge after the terminating `=` is sampled, and is high for exactly one cycle.
- `busy` is high from the START cycle through the cycle in which `calc_done` is sampled.
- Return path: A is re-entered and `busy` falls on the edge after `calc_done`.
- `calc_done` outside WAIT is ignored.
- `rx_valid` and `calc_done` in the same WAIT cycle: `calc_done` wins and the byte is dropped.
- A clear key and an error condition cannot coincide, because each cycle carries a single byte.
- `reset` mid-operation, including during START or WAIT, returns all outputs to reset values on the next edge. No `calc_start` is emitted afterwards.

## Test plan
- **Basic add:** send `"12+34="`.
  - `calc_start` pulses once, 1 cycle after `'='` is sampled.
  - At the pulse, `op_a = 12`, `op_b = 34`, `op_code = 00`, `busy = 1`.
  - Assert `calc_done` 5 cycles later; `busy` falls 1 cycle after it and `op_a = 0`.
- **Back-to-back bytes:** send `"9999*9999"` then CR on consecutive cycles.
  - `op_a = op_b = 9999`, `op_code = 10`, one `calc_start`.
- **Digit limit:** send `"12345"`.
  - `err = 1` after the 5th digit; `op_a = 1234`.
  - Send `'x'`: stays in ERR.
  - Send `'c'`: `err = 0`, `op_a = 0`.
- **Divide by zero and bad operator:** send `"7/0="`.
  - `err = 1` and no `calc_start`.
  - Clear with ESC, then send `"+5"`: `err = 1` (operator with no digits).
- **Busy interval:** send `"3-1="`, then `"8+"` and `'C'` while `busy`.
  - All are dropped and the operands stay 3 and 1.
  - `calc_done` with simultaneous `rx_valid` `'4'`: returns to A with `op_a = 0`.
- **Reset mid-operation:** assert `reset` in the WAIT cycle after `"5*6="`.
  - All outputs return to reset values next cycle.
  - A later `calc_done` produces no state change.

Source files
------------

// File: rtl/calc_cmd_sequencer.sv
// Command sequencer: assembles "<A><op><B>=" from received ASCII bytes,
// launches one ALU operation and waits for its completion.
module calc_cmd_sequencer #(
   parameter int DIGITS = 4,
   parameter int WIDTH  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic             calc_done,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [1:0]       op_code,
   output logic             calc_start,
   output logic             busy,
   output logic             err
);

   localparam int CW = $clog2(DIGITS + 1);

   typedef enum logic [2:0] {S_A, S_B, S_START, S_WAIT, S_ERR} state_t;

   state_t           state;
   logic [CW-1:0]    cnt_a;
   logic [CW-1:0]    cnt_b;

   logic             is_digit;
   logic             is_op;
   logic             is_eq;
   logic             is_clr;
   logic             go_a;
   logic [1:0]       op_enc;
   logic [WIDTH-1:0] digit;

   assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_op    = (rx_data == 8'h2B) || (rx_data == 8'h2D) ||
                     (rx_data == 8'h2A) || (rx_data == 8'h2F);
   assign is_eq    = (rx_data == 8'h3D) || (rx_data == 8'h0D);
   assign is_clr   = (rx_data == 8'h43) || (rx_data == 8'h63) || (rx_data == 8'h1B);
   // For '0'..'9' the low nibble already equals rx_data - 0x30.
   assign digit    = WIDTH'(rx_data[3:0]);

   // Any path that re-enters A: clear key while accepting input, or ALU completion.
   assign go_a = (rx_valid && is_clr &&
                  (state == S_A || state == S_B || state == S_ERR)) ||
                 (state == S_WAIT && calc_done);

   // Map the operator character onto the ALU opcode.
   always_comb begin
      op_enc = 2'b00;
      case (rx_data)
         8'h2D:   op_enc = 2'b01;
         8'h2A:   op_enc = 2'b10;
         8'h2F:   op_enc = 2'b11;
         default: op_enc = 2'b00;
      endcase
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset || go_a) begin
         state      <= S_A;
         op_a       <= '0;
         op_b       <= '0;
         op_code    <= 2'b00;
         cnt_a      <= '0;
         cnt_b      <= '0;
         calc_start <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         calc_start <= 1'b0;
         case (state)
            S_A: begin
               if (rx_valid) begin
                  if (is_digit && cnt_a != CW'(DIGITS)) begin
                     op_a  <= op_a * WIDTH'(10) + digit;
                     cnt_a <= cnt_a + CW'(1);
                  end else if (is_op && cnt_a != '0) begin
                     op_code <= op_enc;
                     state   <= S_B;
                  end else begin
                     // Digit overflow, operator without digits, '=' in A, or junk.
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
            end
            S_B: begin
               if (rx_valid) begin
                  if (is_digit && cnt_b != CW'(DIGITS)) begin
                     op_b  <= op_b * WIDTH'(10) + digit;
                     cnt_b <= cnt_b + CW'(1);
                  end else if (is_eq && cnt_b != '0 &&
                               !(op_code == 2'b11 && op_b == '0)) begin
                     state      <= S_START;
                     calc_start <= 1'b1;
                     busy       <= 1'b1;
                  end else begin
                     // Digit overflow, second operator, empty B, divide by zero, or junk.
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
            end
            S_START: state <= S_WAIT;
            S_WAIT:  state <= S_WAIT;
            S_ERR:   state <= S_ERR;
            default: begin
               state <= S_ERR;
               err   <= 1'b1;
            end
         endcase
      end
   end

endmodule
